// File: rtl/bf16_pkg.sv
// ---------------------------------------------------------------------------
// bf16_pkg
// Shared constants for the BF16 multiplier scheduling slice.
//   BF16_W        width of one BF16 word
//   BF16_QNAN     canonical quiet NaN
//   BF16_ONE      1.0
//   BF16_DEF_LAT  default latency of the shared pipelined multiplier
// ---------------------------------------------------------------------------
package bf16_pkg;

    localparam int BF16_W = 16;
    localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;
    localparam logic [BF16_W-1:0] BF16_ONE = 16'h3F80;
    localparam int BF16_DEF_LAT = 3;

endpackage

// File: rtl/bf16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_rr_arbiter
// Round-robin arbiter. The search starts at rr_ptr and walks upward modulo
// N. After a grant to g the pointer moves to g+1 so g becomes lowest priority.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req [N]      request vector
//   en           grant enable (no grant when low)
//   gnt [N]      one-hot grant, combinational
//   gnt_id       binary index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module bf16_rr_arbiter
    import bf16_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   idx;
    logic            found;

    // Priority search from rr_ptr. The index carries one extra bit so the
    // modulo-N wrap works for requester counts that are not powers of two.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (en && !found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[ID_W-1:0];
            end
        end
        if (found) begin
            gnt = N'(1) << gnt_id;
        end
    end

    // Pointer advances past the winner; idle cycles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (gnt_id == ID_W'(N-1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/bf16mult_rr_sched.sv
// ---------------------------------------------------------------------------
// bf16mult_rr_sched
// Shares one fixed-latency pipelined BF16 multiplier among NUM_REQ
// requesters. At most one operand pair is issued per cycle; the requester ID
// rides a tag pipe alongside the multiplier so every result comes back
// labelled with its owner.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   issue_en          gate for new grants (in-flight work still drains)
//   req_valid/ready   per-requester handshake, ready is one-hot combinational
//   req_a, req_b      packed operands, requester i at [16i+15:16i]
//   mul_a, mul_b      registered operands to the multiplier
//   mul_valid_in      registered issue strobe
//   mul_result        multiplier result
//   mul_valid_out     multiplier result strobe
//   rsp_valid/id/result  tagged response, no backpressure
//   tag_err           sticky: multiplier strobe disagreed with the tag pipe
// Optional (macro BF16SCHED_PERF_EN):
//   cnt_clr           synchronous clear of the grant counters
//   grant_cnt         per-requester 32-bit grant counters, requester i at
//                     [32i+31:32i]
// ---------------------------------------------------------------------------
module bf16mult_rr_sched
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MULT_LAT = BF16_DEF_LAT,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [BF16_W*NUM_REQ-1:0] req_a,
    input  logic [BF16_W*NUM_REQ-1:0] req_b,
    output logic [BF16_W-1:0]         mul_a,
    output logic [BF16_W-1:0]         mul_b,
    output logic                      mul_valid_in,
    input  logic [BF16_W-1:0]         mul_result,
    input  logic                      mul_valid_out,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [BF16_W-1:0]         rsp_result,
    output logic                      tag_err
`ifdef BF16SCHED_PERF_EN
    ,
    input  logic                      cnt_clr,
    output logic [32*NUM_REQ-1:0]     grant_cnt
`endif
);

    logic [NUM_REQ-1:0]          gnt;
    logic [ID_W-1:0]             gnt_id;
    logic                        transfer;
    logic [MULT_LAT:0]           tag_vld;
    logic [MULT_LAT:0][ID_W-1:0] tag_id;

    bf16_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .en     (issue_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // A grant is only ever given to a valid requester, so any grant is a
    // transfer.
    assign req_ready = gnt;
    assign transfer  = |gnt;

    // Operand register in front of the multiplier; operands hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
        end else begin
            mul_valid_in <= transfer;
            if (transfer) begin
                mul_a <= req_a[BF16_W*gnt_id +: BF16_W];
                mul_b <= req_b[BF16_W*gnt_id +: BF16_W];
            end
        end
    end

    // Tag pipe. Stage 0 is loaded together with the operand register; the
    // following MULT_LAT stages track the multiplier's internal stages, so
    // the last stage lines up with mul_valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= transfer;
            tag_id[0]  <= gnt_id;
            for (int s = 1; s <= MULT_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Sticky alignment check between the multiplier strobe and the tag pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_err <= 1'b0;
        end else if (mul_valid_out != tag_vld[MULT_LAT]) begin
            tag_err <= 1'b1;
        end
    end

    assign rsp_valid  = mul_valid_out;
    assign rsp_result = mul_result;
    assign rsp_id     = tag_id[MULT_LAT];

`ifdef BF16SCHED_PERF_EN
    logic [NUM_REQ-1:0][31:0] cnt;

    // Clear wins over a same-cycle grant; counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    cnt[i] <= cnt[i] + 32'd1;
                end
            end
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_bf16mult_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_bf16mult_rr_sched
// Bench for bf16mult_rr_sched with a stand-in pipelined BF16 multiplier.
// Optional counters are exercised when BF16SCHED_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_bf16mult_rr_sched;
    import bf16_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int MULT_LAT = BF16_DEF_LAT;
    localparam int ID_W     = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      issue_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BF16_W*NUM_REQ-1:0] req_a;
    logic [BF16_W*NUM_REQ-1:0] req_b;
    logic [BF16_W-1:0]         mul_a;
    logic [BF16_W-1:0]         mul_b;
    logic                      mul_valid_in;
    logic [BF16_W-1:0]         mul_result;
    logic                      mul_valid_out;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [BF16_W-1:0]         rsp_result;
    logic                      tag_err;
`ifdef BF16SCHED_PERF_EN
    logic                      cnt_clr;
    logic [32*NUM_REQ-1:0]     grant_cnt;
`endif

    always #5 clk = ~clk;

    bf16mult_rr_sched #(
        .NUM_REQ  (NUM_REQ),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_en      (issue_en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_in  (mul_valid_in),
        .mul_result    (mul_result),
        .mul_valid_out (mul_valid_out),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .tag_err       (tag_err)
`ifdef BF16SCHED_PERF_EN
        ,
        .cnt_clr       (cnt_clr),
        .grant_cnt     (grant_cnt)
`endif
    );

    // Simple BF16 product (normals, truncating) used by the stand-in
    // multiplier and by the expected-result model.
    function automatic logic [15:0] mult_model(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [15:0] p;
        logic [6:0]  m;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'h0};
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            m = p[14:8];
            e = e + 1;
        end else begin
            m = p[13:7];
        end
        if (e <= 0) return {s, 15'h0};
        if (e >= 255) return {s, 8'hFF, 7'h0};
        return {s, 8'(e), m};
    endfunction

    function automatic logic [15:0] rand_bf16();
        return {1'($urandom), 8'($urandom_range(110, 140)), 7'($urandom)};
    endfunction

    // Stand-in multiplier: MULT_LAT register stages, reset with the DUT.
    logic [MULT_LAT-1:0] pipe_v;
    logic [15:0]         pipe_r [MULT_LAT];
    logic                inject_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int s = 0; s < MULT_LAT; s++) pipe_r[s] <= '0;
        end else begin
            pipe_v    <= {pipe_v[MULT_LAT-2:0], mul_valid_in};
            pipe_r[0] <= mult_model(mul_a, mul_b);
            for (int s = 1; s < MULT_LAT; s++) pipe_r[s] <= pipe_r[s-1];
        end
    end

    assign mul_valid_out = pipe_v[MULT_LAT-1] | inject_err;
    assign mul_result    = pipe_r[MULT_LAT-1];

    // Reference model state: round-robin pointer and expected responses.
    typedef struct {
        int          id;
        logic [15:0] res;
        int          due;
    } rsp_t;

    rsp_t               exp_q[$];
    int                 ptr;
    int                 cyc;
    int                 n_cmp;
    int                 n_err;
    logic [15:0]        a_op [NUM_REQ];
    logic [15:0]        b_op [NUM_REQ];
    logic [NUM_REQ-1:0] held;
    bit                 fixed_ops;

    // Per-cycle snapshot filled by applyStimulus.
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] obs_ready;
    bit                 exp_rv;
    int                 exp_id;
    logic [15:0]        exp_res;
    logic               obs_rv;
    logic [ID_W-1:0]    obs_id;
    logic [15:0]        obs_res;
    logic [15:0]        obs_ma;
    logic [15:0]        obs_mb;
    logic               obs_mvi;
    logic               obs_terr;

    // Drive one cycle of requests, capture DUT outputs away from the edge,
    // and advance the model at the clock edge.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic en);
        int gid;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!fixed_ops && !held[i]) begin
                a_op[i] = rand_bf16();
                b_op[i] = rand_bf16();
            end
            req_a[16*i +: 16] = a_op[i];
            req_b[16*i +: 16] = b_op[i];
        end
        req_valid = v;
        issue_en  = en;
        #1;
        gid = -1;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gid < 0 && v[(ptr + k) % NUM_REQ]) gid = (ptr + k) % NUM_REQ;
            end
        end
        exp_ready = (gid >= 0) ? (NUM_REQ'(1) << gid) : '0;
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_id    = rsp_id;
        obs_res   = rsp_result;
        obs_ma    = mul_a;
        obs_mb    = mul_b;
        obs_mvi   = mul_valid_in;
        obs_terr  = tag_err;
        exp_rv    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_id    = 0;
        exp_res   = '0;
        if (exp_rv) begin
            exp_id  = exp_q[0].id;
            exp_res = exp_q[0].res;
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        if (gid >= 0) begin
            exp_q.push_back('{gid, mult_model(a_op[gid], b_op[gid]), cyc + MULT_LAT});
            ptr = (gid + 1) % NUM_REQ;
        end
        held = v & ~exp_ready;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ptr  = 0;
        held = '0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        issue_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mul_valid_in !== 1'b0) begin n_err++; $display("[TB] FAIL reset_mvi: got %b expected 0", mul_valid_in); end
        n_cmp++; if ({mul_a, mul_b} !== 32'h0) begin n_err++; $display("[TB] FAIL reset_ops: got %h expected 0", {mul_a, mul_b}); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== '0) begin n_err++; $display("[TB] FAIL reset_rsp: got v=%b id=%0d expected v=0 id=0", rsp_valid, rsp_id); end
        n_cmp++; if (tag_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tagerr: got %b expected 0", tag_err); end
        rst_n = 1'b1;
        exp_q.delete();
        ptr  = 0;
        held = '0;
        applyStimulus('1, 1'b1);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL reset_ptr: got %b expected 0001", obs_ready); end
        for (int k = 0; k < 6; k++) applyStimulus('0, 1'b1);
    endtask

    task automatic test_single();
        fixed_ops = 1;
        a_op[2]   = 16'h4000;
        b_op[2]   = 16'h4040;
        applyStimulus(4'b0100, 1'b1);
        n_cmp++; if (obs_ready !== 4'b0100) begin n_err++; $display("[TB] FAIL single_grant: got %b expected 0100", obs_ready); end
        for (int k = 1; k <= 6; k++) begin
            applyStimulus('0, 1'b1);
            if (k == 1) begin
                n_cmp++; if (obs_mvi !== 1'b1 || obs_ma !== 16'h4000 || obs_mb !== 16'h4040) begin n_err++; $display("[TB] FAIL single_issue: got v=%b a=%h b=%h expected v=1 a=4000 b=4040", obs_mvi, obs_ma, obs_mb); end
            end
            n_cmp++; if (obs_rv !== (k == 4)) begin n_err++; $display("[TB] FAIL single_latency: cycle %0d got rsp_valid=%b expected %b", k, obs_rv, (k == 4)); end
            if (k == 4) begin
                n_cmp++; if (obs_id !== 2'd2 || obs_res !== 16'h40C0) begin n_err++; $display("[TB] FAIL single_rsp: got id=%0d res=%h expected id=2 res=40c0", obs_id, obs_res); end
            end
        end
        fixed_ops = 0;
    endtask

    task automatic test_wrap();
        applyStimulus(4'b1000, 1'b1);
        n_cmp++; if (obs_ready !== 4'b1000) begin n_err++; $display("[TB] FAIL wrap_g3: got %b expected 1000", obs_ready); end
        applyStimulus(4'b1001, 1'b1);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL wrap_g0: got %b expected 0001", obs_ready); end
        applyStimulus(4'b1000, 1'b1);
        n_cmp++; if (obs_ready !== 4'b1000) begin n_err++; $display("[TB] FAIL wrap_g3b: got %b expected 1000", obs_ready); end
        for (int k = 0; k < 6; k++) begin
            applyStimulus('0, 1'b1);
            n_cmp++; if (obs_rv !== exp_rv || (exp_rv && (obs_id !== ID_W'(exp_id) || obs_res !== exp_res))) begin n_err++; $display("[TB] FAIL wrap_rsp: got v=%b id=%0d res=%h expected v=%b id=%0d res=%h", obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res); end
        end
    endtask

    task automatic test_back_to_back();
`ifdef BF16SCHED_PERF_EN
        cnt_clr = 1'b1;
        applyStimulus('0, 1'b1);
        cnt_clr = 1'b0;
`endif
        fixed_ops = 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = BF16_ONE;
            b_op[i] = BF16_ONE;
        end
        for (int k = 0; k < 14; k++) begin
            applyStimulus((k < 8) ? '1 : '0, 1'b1);
            n_cmp++; if (obs_ready !== ((k < 8) ? (4'b0001 << (k % 4)) : 4'b0000)) begin n_err++; $display("[TB] FAIL b2b_grant: step %0d got %b expected %b", k, obs_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000); end
            n_cmp++; if (obs_rv !== (k >= 4 && k < 12)) begin n_err++; $display("[TB] FAIL b2b_valid: step %0d got %b expected %b", k, obs_rv, (k >= 4 && k < 12)); end
            if (k >= 4 && k < 12) begin
                n_cmp++; if (obs_id !== ID_W'((k - 4) % 4) || obs_res !== 16'h3F80) begin n_err++; $display("[TB] FAIL b2b_rsp: step %0d got id=%0d res=%h expected id=%0d res=3f80", k, obs_id, obs_res, (k - 4) % 4); end
            end
`ifdef BF16SCHED_PERF_EN
            if (k == 8) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    n_cmp++; if (grant_cnt[32*i +: 32] !== 32'd2) begin n_err++; $display("[TB] FAIL cnt_run: req %0d got %0d expected 2", i, grant_cnt[32*i +: 32]); end
                end
            end
`endif
        end
        fixed_ops = 0;
`ifdef BF16SCHED_PERF_EN
        cnt_clr = 1'b1;
        applyStimulus('0, 1'b1);
        cnt_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (grant_cnt !== '0) begin n_err++; $display("[TB] FAIL cnt_clr: got %h expected 0", grant_cnt); end
        cnt_clr = 1'b1;
        applyStimulus(4'b0010, 1'b1);
        cnt_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (grant_cnt !== '0) begin n_err++; $display("[TB] FAIL cnt_clr_grant: got %h expected 0", grant_cnt); end
        for (int k = 0; k < 6; k++) applyStimulus('0, 1'b1);
`endif
    endtask

    task automatic test_issue_en();
        int seen;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0011, 1'b1);
            n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("[TB] FAIL en_issue: got %b expected %b", obs_ready, exp_ready); end
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus('1, 1'b0);
            n_cmp++; if (obs_ready !== 4'b0000) begin n_err++; $display("[TB] FAIL en_gate: got %b expected 0000", obs_ready); end
            n_cmp++; if (obs_rv !== exp_rv || (exp_rv && (obs_id !== ID_W'(exp_id) || obs_res !== exp_res))) begin n_err++; $display("[TB] FAIL en_drain: got v=%b id=%0d res=%h expected v=%b id=%0d res=%h", obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res); end
            if (obs_rv === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 2) begin n_err++; $display("[TB] FAIL en_count: got %0d expected 2", seen); end
        for (int k = 0; k < 6; k++) applyStimulus('0, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            applyStimulus(NUM_REQ'($urandom), ($urandom_range(0, 7) != 0));
            n_cmp++; if (obs_ready !== exp_ready) begin n_err++; $display("[TB] FAIL rand_grant: cycle %0d got %b expected %b", cyc, obs_ready, exp_ready); end
            n_cmp++; if (obs_rv !== exp_rv || (exp_rv && (obs_id !== ID_W'(exp_id) || obs_res !== exp_res))) begin n_err++; $display("[TB] FAIL rand_rsp: cycle %0d got v=%b id=%0d res=%h expected v=%b id=%0d res=%h", cyc, obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res); end
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus('0, 1'b1);
            n_cmp++; if (obs_rv !== exp_rv || (exp_rv && (obs_id !== ID_W'(exp_id) || obs_res !== exp_res))) begin n_err++; $display("[TB] FAIL rand_drain: got v=%b id=%0d res=%h expected v=%b id=%0d res=%h", obs_rv, obs_id, obs_res, exp_rv, exp_id, exp_res); end
        end
        n_cmp++; if (obs_terr !== 1'b0) begin n_err++; $display("[TB] FAIL rand_tagerr: got %b expected 0", obs_terr); end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) applyStimulus('1, 1'b1);
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus('0, 1'b1);
            n_cmp++; if (obs_rv !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_rsp: step %0d got %b expected 0", k, obs_rv); end
        end
        n_cmp++; if (obs_terr !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_tagerr: got %b expected 0", obs_terr); end
        applyStimulus('1, 1'b1);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_err++; $display("[TB] FAIL midrst_ptr: got %b expected 0001", obs_ready); end
        for (int k = 0; k < 6; k++) applyStimulus('0, 1'b1);
    endtask

    task automatic test_tag_err();
        inject_err = 1'b1;
        applyStimulus('0, 1'b1);
        inject_err = 1'b0;
        applyStimulus('0, 1'b1);
        n_cmp++; if (obs_terr !== 1'b1) begin n_err++; $display("[TB] FAIL tagerr_set: got %b expected 1", obs_terr); end
        for (int k = 0; k < 3; k++) applyStimulus('0, 1'b1);
        n_cmp++; if (obs_terr !== 1'b1) begin n_err++; $display("[TB] FAIL tagerr_sticky: got %b expected 1", obs_terr); end
        doReset();
        applyStimulus('0, 1'b1);
        n_cmp++; if (obs_terr !== 1'b0) begin n_err++; $display("[TB] FAIL tagerr_clear: got %b expected 0", obs_terr); end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        ptr        = 0;
        cyc        = 0;
        held       = '0;
        fixed_ops  = 0;
        inject_err = 1'b0;
        issue_en   = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
`ifdef BF16SCHED_PERF_EN
        cnt_clr    = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        $display("[TB] starting bf16mult_rr_sched bench");
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_issue_en();
        test_random();
        test_reset_midflight();
        test_tag_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
